// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: two-port access controller / arbiter in front of the
// 64-bit-word data_sram. Converts byte-addressed 1/2/4/8-byte loads and
// stores into whole-word SRAM accesses; sub-word stores are read-modify-write.
// Optional build macro: DSC_RR_ARB_EN selects round-robin arbitration
// (default: fixed priority, port 0 wins).
`timescale 1ns/1ps
module data_sram_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [1:0]   req,
  input  logic [1:0]   req_wr,
  input  logic [3:0]   req_size,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_wdata,
  output logic [1:0]   gnt,
  output logic [1:0]   resp_valid,
  output logic [63:0]  resp_rdata,
  output logic         resp_err,
  output logic         sram_en,
  output logic         sram_wen,
  output logic [63:0]  sram_addr,
  output logic [63:0]  sram_wdata,
  input  logic [63:0]  sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, MRG, RESP} state_t;

  state_t              r_state, w_next;
  logic                r_id, r_wr, r_err;
  logic [1:0]          r_size;
  logic [ADDR_W+2:0]   r_addr;
  logic [63:0]         r_wdata, r_buf, r_rdata;

  logic                w_win, w_grant, w_mis;
  logic [1:0]          w_sel_size;
  logic [ADDR_W+2:0]   w_sel_addr;
  logic [63:0]         w_sel_wdata, w_index;
  logic [5:0]          w_shift;
  logic                w_unused;

  // Byte mask covering 1/2/4/8 low bytes.
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Natural alignment check of the access size against the byte lane.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lane);
    case (sz)
      2'b01:   return lane[0];
      2'b10:   return |lane[1:0];
      2'b11:   return |lane;
      default: return 1'b0;
    endcase
  endfunction

  // Replace bytes [lane, lane+nbytes) of old with the low bytes of wd.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [1:0] sz, input logic [2:0] lane);
    logic [63:0] m;
    logic [5:0]  sh;
    sh = {lane, 3'b000};
    m  = size_mask(sz) << sh;
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  // Upper address bits are not decoded by this 128-word memory.
  assign w_unused = ^{req_addr[127:64+ADDR_W+3], req_addr[63:ADDR_W+3]};

`ifdef DSC_RR_ARB_EN
  logic r_rr_ptr;

  // Winner: preferred port on contention, otherwise whichever requests.
  always_comb begin
    w_win = (req == 2'b11) ? r_rr_ptr : req[1];
  end

  // Round-robin pointer moves to the port that did not just win.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_rr_ptr <= 1'b0;
    else if (w_grant) r_rr_ptr <= ~w_win;
  end
`else
  // Winner: port 0 whenever it requests, else port 1.
  always_comb begin
    w_win = ~req[0];
  end
`endif

  assign w_grant     = (r_state == IDLE) && (|req) && resetn;
  assign w_sel_size  = w_win ? req_size[3:2] : req_size[1:0];
  assign w_sel_addr  = w_win ? req_addr[64+ADDR_W+2:64] : req_addr[ADDR_W+2:0];
  assign w_sel_wdata = w_win ? req_wdata[127:64] : req_wdata[63:0];
  assign w_mis       = misaligned(w_sel_size, w_sel_addr[2:0]);
  assign w_index     = {{(64-ADDR_W){1'b0}}, r_addr[ADDR_W+2:3]};
  assign w_shift     = {r_addr[2:0], 3'b000};

  // State and latched control fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_id   <= w_win;
        r_wr   <= w_win ? req_wr[1] : req_wr[0];
        r_size <= w_sel_size;
        r_err  <= w_mis;
      end
    end
  end

  // Latched address/data, load result and merge buffer.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_rdata <= '0;
    end else if (r_state == ACC) begin
      if (!r_wr) r_rdata <= (sram_rdata >> w_shift) & size_mask(r_size);
      r_buf <= sram_rdata;
    end
  end

  // Next state, grant, SRAM strobes and response decode.
  always_comb begin
    w_next     = r_state;
    gnt        = 2'b00;
    resp_valid = 2'b00;
    resp_rdata = '0;
    resp_err   = 1'b0;
    sram_en    = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          gnt[w_win] = 1'b1;
          w_next     = w_mis ? RESP : ACC;
        end
      end
      ACC: begin
        sram_en   = 1'b1;
        sram_addr = w_index;
        if (r_wr && (r_size == 2'b11)) begin
          sram_wen   = 1'b1;
          sram_wdata = r_wdata;
          w_next     = RESP;
        end else if (r_wr) begin
          w_next = MRG;
        end else begin
          w_next = RESP;
        end
      end
      MRG: begin
        sram_en    = 1'b1;
        sram_wen   = 1'b1;
        sram_addr  = w_index;
        sram_wdata = merge_bytes(r_buf, r_wdata, r_size, r_addr[2:0]);
        w_next     = RESP;
      end
      RESP: begin
        resp_valid[r_id] = 1'b1;
        resp_err         = r_err;
        resp_rdata       = (r_wr || r_err) ? 64'd0 : r_rdata;
        w_next           = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Access controller and two-port arbiter in front of the 64-bit-word data_sram.
- Accepts byte-addressed load/store requests of 1/2/4/8 bytes from two requesters: port 0 = LSU memory stage, port 1 = loader/debug.
- Grants one request at a time and converts the byte address to a word index.
- Full-dword stores are written directly; sub-word stores are done as read-modify-write because the SRAM has only a whole-word write enable.

Parameters:
- ADDR_W, 7: word-index width actually decoded (128 words); sram_addr upper bits are driven 0.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  2  per-port request, held until gnt
- req_wr  in  2  per-port: 1 = store, 0 = load
- req_size  in  4  per-port 2-bit size {p1,p0}: 00 = byte, 01 = half, 10 = word, 11 = dword
- req_addr  in  128  per-port 64-bit byte address {p1,p0}
- req_wdata  in  128  per-port store data, right-aligned {p1,p0}
- gnt  out  2  one-hot grant pulse, one cycle
- resp_valid  out  2  one-hot response pulse, one cycle
- resp_rdata  out  64  load data, right-aligned, zero-extended
- resp_err  out  1  misaligned access, valid with resp_valid
- sram_en  out  1  to data_sram_en
- sram_wen  out  1  to data_sram_wen
- sram_addr  out  64  word index, to data_sram_addr
- sram_wdata  out  64  to data_sram_wdata
- sram_rdata  in  64  from data_sram_rdata (combinational read)

Behaviour:
- Reset (resetn = 0, async): state = IDLE, rr_ptr = 0. All outputs 0: gnt, resp_valid, resp_rdata, resp_err, sram_en, sram_wen, sram_addr, sram_wdata.
- SRAM outputs decode only from registered state and latched request; no combinational path from req_* to sram_*.
- Word index = addr[ADDR_W+2:3], zero-extended to 64. Byte lane = addr[2:0].
- Misaligned: half with addr[0] != 0; word with addr[1:0] != 0; dword with addr[2:0] != 0.
- FSM states: IDLE, ACC, MRG, RESP.
- IDLE:
  - If any req, assert gnt for the arbitration winner in this cycle.
  - Latch its wr/size/addr/wdata/port id.
  - Misaligned -> RESP with err = 1. Otherwise -> ACC.
- ACC:
  - sram_en = 1, sram_addr = index.
  - Load: capture sram_rdata >> (8*lane), masked to size -> RESP.
  - Dword store: sram_wen = 1, sram_wdata = wdata -> RESP.
  - Sub-word store: capture sram_rdata into merge buffer -> MRG.
- MRG:
  - sram_en = 1, sram_wen = 1.
  - sram_wdata = buffer with bytes [lane, lane+nbytes) replaced by the low bytes of wdata -> RESP.
- RESP:
  - resp_valid[id] = 1 for one cycle with resp_rdata/resp_err.
  - resp_rdata = 0 for stores and errors.
  - -> IDLE.
- Latency from the gnt cycle T:
  - load / dword store: resp at T+2.
  - sub-word store: resp at T+3.
  - misaligned: resp at T+1, no SRAM access.
- Throughput: one request in flight; gnt never asserted outside IDLE. A new grant can occur in the cycle after RESP.
- Both req asserted in IDLE: arbitration picks one; the other keeps req high and is served next.
- A req deasserted before gnt is dropped silently.
- Reset mid-operation: the FSM aborts, no pending write is issued after reset deassertion, and the response is lost.

Optional Feature:
- DSC_RR_ARB_EN defined: round-robin arbitration. rr_ptr names the preferred port; after each grant, rr_ptr = the other port.
- DSC_RR_ARB_EN undefined: fixed priority, port 0 always wins; rr_ptr is not implemented.

Test Plan:
- Reset, then port 0 dword store addr 0x10 data 0x1122334455667788 -> gnt0 at T; at T+1 sram_wen = 1, sram_addr = 2; resp_valid0 at T+2, err = 0.
- Port 0 load dword 0x10 after the above -> resp_rdata = 0x1122334455667788 at T+2.
- Byte store addr 0x13 data 0xAB, then dword load 0x10 -> 0x11223344AB667788; store response at T+3, with MRG sram_wdata equal to that value.
- Half load addr 0x12 -> resp_rdata = 0x000000000000AB66. Word store addr 0x12 -> resp_err = 1 at T+1, no sram_en/sram_wen pulse, memory unchanged.
- Both ports request continuously:
  - with DSC_RR_ARB_EN, grants alternate 0, 1, 0, 1;
  - without it, only port 0 is granted until it drops req.
- Assert resetn = 0 during MRG of a byte store -> outputs 0 immediately, no sram_wen after release, target word retains its old value.
